fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter: PC_WIDTH, 32, address width.
REQ-002 SHALL have parameter: DEPTH, 4, fetch queue entries (power of 2, >=2).
REQ-003 SHALL have port: clk  in  1  clock, rising-edge.
REQ-004 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: pc_in  in  PC_WIDTH  fetch address from program counter.
REQ-006 SHALL have port: pc_valid  in  1  pc_in valid.
REQ-007 SHALL have port: pc_ready  out  1  pc_in accepted when pc_valid&pc_ready.
REQ-008 SHALL have port: flush  in  1  branch redirect, discard all fetched/in-flight work.
REQ-009 SHALL have port: mem_req  out  1  instruction memory request.
REQ-010 SHALL have port: mem_addr  out  PC_WIDTH  word-aligned request address.
REQ-011 SHALL have port: mem_gnt  in  1  request taken when mem_req&mem_gnt.
REQ-012 SHALL have port: mem_rvalid  in  1  read data valid.
REQ-013 SHALL have port: mem_rdata  in  32  read data.
REQ-014 SHALL have port: instr_valid  out  1  queue head valid.
REQ-015 SHALL have port: instr  out  32  queue head instruction.
REQ-016 SHALL have port: instr_pc  out  PC_WIDTH  PC of queue head.
REQ-017 SHALL have port: instr_ready  in  1  head popped when instr_valid&instr_ready.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT, DROP; one memory transaction outstanding max.
REQ-019 SHALL drive pc_ready = !rst & (state==IDLE) & (count<DEPTH) & !flush; no pop bypass when full.
REQ-020 SHALL on accept latch {pc_in[PC_WIDTH-1:2],2'b00} into addr register, go IDLE->REQ.
REQ-021 SHALL assert mem_req only in REQ, mem_addr = addr register, both stable until mem_gnt.
REQ-022 SHALL go REQ->WAIT on mem_gnt (flush=0), REQ->DROP on mem_gnt with flush, stay REQ otherwise (flush in REQ does not withdraw request; records pending drop).
REQ-023 SHALL in REQ with a recorded flush go to DROP on mem_gnt.
REQ-024 SHALL in WAIT on mem_rvalid & !flush push {addr, mem_rdata} into queue, go IDLE.
REQ-025 SHALL in WAIT on mem_rvalid & flush discard data, go IDLE; WAIT & flush & !mem_rvalid -> DROP.
REQ-026 SHALL in DROP discard data on mem_rvalid, go IDLE.
REQ-027 SHALL ignore mem_rvalid in IDLE and REQ.
REQ-028 SHALL implement queue as circular buffer, DEPTH entries, wrap-around read/write pointers, count 0..DEPTH.
REQ-029 SHALL drive instr_valid = (count!=0); instr/instr_pc = head entry, combinational from storage.
REQ-030 SHALL support push and pop same cycle (count unchanged).
REQ-031 SHALL on flush empty queue next cycle (pointers/count to 0); a simultaneous pop or push is ignored.
REQ-032 SHALL never overflow: capacity checked at accept, push only possible when count<DEPTH.
REQ-033 SHALL have minimum latency: accept edge T, mem_req cycle T+1, gnt at T+1, rvalid at T+2, instr_valid at T+3.
REQ-034 SHALL ignore pc_in[1:0].

Reset
REQ-035 SHALL on rst asynchronously set state IDLE, queue empty, pending-drop flag 0, addr register 0.
REQ-036 SHALL hold mem_req=0, instr_valid=0, pc_ready=0, mem_addr=0 while rst high.
REQ-037 SHALL abandon any outstanding transaction on reset mid-operation; a later mem_rvalid in IDLE is ignored.

Verification
REQ-038 SHALL cover: pc 0x0,0x4,0x8 accepted, gnt/rvalid zero-wait -> instr_pc 0x0,0x4,0x8 in order, first instr_valid 3 cycles after accept.
REQ-039 SHALL cover: instr_ready=0, 5 fetches, DEPTH=4 -> pc_ready=0 after 4th accept; one pop -> 5th accepted, pointers wrap, order preserved.
REQ-040 SHALL cover: flush in WAIT before rvalid, rdata 0xDEADBEEF 3 cycles later -> DROP, data not queued, instr_valid=0.
REQ-041 SHALL cover: flush in REQ, mem_gnt 2 cycles later -> mem_addr held, DROP, response discarded.
REQ-042 SHALL cover: pc_in 0x1007 -> mem_addr 0x1004, instr_pc 0x1004.
REQ-043 SHALL cover: rst pulse in WAIT with 2 queued entries -> mem_req=0, instr_valid=0 asynchronously; stray mem_rvalid afterwards ignored.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Instruction fetch front end: accepts fetch addresses, issues one
//   instruction-memory read at a time and queues {pc, instruction} pairs
//   in a small circular buffer for the decoder.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   pc_in/pc_valid      fetch address from the PC; pc_ready = accept
//   flush               branch redirect: drop queue and in-flight response
//   mem_req/mem_addr    instruction memory request, word-aligned address
//   mem_gnt             request taken when mem_req & mem_gnt
//   mem_rvalid/rdata    read response
//   instr_valid/instr/  queue head (combinational from storage)
//   instr_pc
//   instr_ready         head popped when instr_valid & instr_ready
module fetch_buffer #(
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic                pc_valid,
  output logic                pc_ready,
  input  logic                flush,
  output logic                mem_req,
  output logic [PC_WIDTH-1:0] mem_addr,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [31:0]         mem_rdata,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  input  logic                instr_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                drop_pend;
  logic                drop_pend_nxt;
  logic [PC_WIDTH-1:0] addr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [31:0]         data_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem   [DEPTH];
  logic                accept;
  logic                push;
  logic                pop;
  logic [1:0]          unused_pc_lsb;

  // Byte offset of the fetch address is irrelevant for word fetches.
  assign unused_pc_lsb = pc_in[1:0];

  // A new fetch is only taken when the memory port is free and a queue slot
  // is guaranteed, so a response can always be pushed without a full check.
  // A same-cycle pop deliberately does not free a slot for the accept.
  assign pc_ready    = !rst && (state == IDLE) && (count < DEPTH_C) && !flush;
  assign accept      = pc_valid && pc_ready;
  assign mem_req     = (state == REQ);
  assign mem_addr    = addr;
  assign instr_valid = (count != '0);
  assign instr       = data_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];
  assign push        = (state == WAIT) && mem_rvalid && !flush;
  assign pop         = instr_valid && instr_ready && !flush;

  // A flush while the request is still waiting for grant cannot withdraw it;
  // drop_pend remembers that its response must be thrown away.
  always_comb begin
    state_nxt     = state;
    drop_pend_nxt = drop_pend;
    case (state)
      IDLE: begin
        if (accept) state_nxt = REQ;
      end
      REQ: begin
        if (mem_gnt) begin
          state_nxt     = (flush || drop_pend) ? DROP : WAIT;
          drop_pend_nxt = 1'b0;
        end else if (flush) begin
          drop_pend_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid)  state_nxt = IDLE;
        else if (flush)  state_nxt = DROP;
      end
      DROP: begin
        if (mem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, request address, queue pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drop_pend <= 1'b0;
      addr      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      drop_pend <= drop_pend_nxt;
      if (accept) addr <= {pc_in[PC_WIDTH-1:2], 2'b00};
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Queue storage: data only, never reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= mem_rdata;
      pc_mem[wr_ptr]   <= addr;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int errors;
  int checks;
  logic [63:0] sb[$];

  fetch_buffer #(.PC_WIDTH(32), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One zero-wait fetch. Entered and left at a negedge. Returns the observed
  // request. When keep is set the expected entry goes to the scoreboard; when
  // pop_on_push is set the head is popped on the same edge as the push.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data,
                          input bit keep, input bit pop_on_push,
                          output logic seen_req, output logic [31:0] seen_addr);
    int n;
    n = 0;
    seen_req  = 1'b0;
    seen_addr = '0;
    pc_valid  = 1'b1;
    pc_in     = pc;
    #1;
    while (pc_ready !== 1'b1 && n < 20) begin
      tick();
      #1;
      n++;
    end
    if (pc_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pc_ready=%b required 1 for pc %h", pc_ready, pc);
      pc_valid = 1'b0;
      return;
    end
    tick();
    pc_valid  = 1'b0;
    seen_req  = mem_req;
    seen_addr = mem_addr;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    if (pop_on_push) begin
      instr_ready = 1'b1;
      void'(sb.pop_front());
    end
    if (keep) sb.push_back({pc[31:2], 2'b00, data});
    tick();
    mem_rvalid  = 1'b0;
    if (pop_on_push) instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pc_valid = 1'b1;
    pc_in = 32'h0000_1234;
    @(negedge clk);
    #1;
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL reset_pc_ready: got %b required 0", pc_ready); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b required 0", mem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b required 0", instr_valid); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h required 0", mem_addr); end
    pc_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL post_reset_pc_ready: got %b required 1", pc_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic        r;
    logic [31:0] a;
    logic [63:0] exp;
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
    instr_ready = 1'b1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b required 0", instr_valid); end
    for (int i = 0; i < 3; i++) begin
      do_fetch(pcs[i], 32'h1111_0000 + i, 1'b1, 1'b0, r, a);
      checks++; if (r !== 1'b1 || a !== pcs[i]) begin errors++; $display("FAIL basic_req%0d: got req=%b addr=%h required 1 %h", i, r, a, pcs[i]); end
      exp = sb.pop_front();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_latency%0d: instr_valid=%b required 1", i, instr_valid); end
      checks++; if (instr_pc !== exp[63:32] || instr !== exp[31:0]) begin errors++; $display("FAIL basic_head%0d: got %h/%h required %h/%h", i, instr_pc, instr, exp[63:32], exp[31:0]); end
    end
    tick();
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: instr_valid=%b required 0", instr_valid); end
  endtask

  task automatic test_full_wrap();
    logic        r;
    logic [31:0] a;
    logic [63:0] exp;
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      do_fetch(32'h200 + 32'(4 * i), 32'hC0DE_0000 + i, 1'b1, 1'b0, r, a);
    pc_valid = 1'b1;
    pc_in    = 32'h210;
    #1;
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL full_pc_ready: got %b required 0", pc_ready); end
    checks++; if (instr_pc !== sb[0][63:32]) begin errors++; $display("FAIL full_head: got %h required %h", instr_pc, sb[0][63:32]); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    void'(sb.pop_front());
    do_fetch(32'h210, 32'hC0DE_0004, 1'b1, 1'b0, r, a);
    checks++; if (a !== 32'h210) begin errors++; $display("FAIL wrap_addr: got %h required 00000210", a); end
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = sb.pop_front();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== exp[63:32] || instr !== exp[31:0]) begin
        errors++; $display("FAIL wrap_order%0d: got v=%b %h/%h required %h/%h", i, instr_valid, instr_pc, instr, exp[63:32], exp[31:0]);
      end
      tick();
    end
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %b required 0", instr_valid); end
  endtask

  task automatic test_flush_wait();
    logic        r;
    logic [31:0] a;
    instr_ready = 1'b0;
    do_fetch(32'h100, 32'h0000_0100, 1'b1, 1'b0, r, a);
    pc_valid = 1'b1;
    pc_in    = 32'h40;
    tick();
    pc_valid = 1'b0;
    mem_gnt  = 1'b1;
    tick();
    mem_gnt = 1'b0;
    flush   = 1'b1;
    #1;
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL flushw_pc_ready: got %b required 0", pc_ready); end
    tick();
    flush = 1'b0;
    sb.delete();
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flushw_queue: instr_valid=%b required 0", instr_valid); end
    checks++; if (pc_ready !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL flushw_drop: pc_ready=%b mem_req=%b required 0 0", pc_ready, mem_req); end
    tick();
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flushw_discard: instr_valid=%b instr=%h required 0", instr_valid, instr); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL flushw_idle: pc_ready=%b required 1", pc_ready); end
  endtask

  task automatic test_flush_req();
    instr_ready = 1'b0;
    pc_valid = 1'b1;
    pc_in    = 32'h80;
    tick();
    pc_valid = 1'b0;
    flush    = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin errors++; $display("FAIL flushr_req: req=%b addr=%h required 1 00000080", mem_req, mem_addr); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin errors++; $display("FAIL flushr_hold1: req=%b addr=%h required 1 00000080", mem_req, mem_addr); end
    tick();
    mem_gnt = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin errors++; $display("FAIL flushr_hold2: req=%b addr=%h required 1 00000080", mem_req, mem_addr); end
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    #1;
    checks++; if (mem_req !== 1'b0 || pc_ready !== 1'b0) begin errors++; $display("FAIL flushr_drop: req=%b pc_ready=%b required 0 0", mem_req, pc_ready); end
    tick();
    mem_rvalid = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flushr_discard: instr_valid=%b required 0", instr_valid); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL flushr_idle: pc_ready=%b required 1", pc_ready); end
  endtask

  task automatic test_align_back_to_back();
    logic        r;
    logic [31:0] a;
    instr_ready = 1'b0;
    do_fetch(32'h1007, 32'hA5A5_0001, 1'b1, 1'b0, r, a);
    checks++; if (a !== 32'h1004) begin errors++; $display("FAIL align_addr: got %h required 00001004", a); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h1004 || instr !== 32'hA5A5_0001) begin
      errors++; $display("FAIL align_head: v=%b %h/%h required 1 00001004/a5a50001", instr_valid, instr_pc, instr);
    end
    do_fetch(32'h2000, 32'hA5A5_0002, 1'b1, 1'b1, r, a);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== sb[0][63:32] || instr !== sb[0][31:0]) begin
      errors++; $display("FAIL pushpop_head: v=%b %h/%h required 1 %h/%h", instr_valid, instr_pc, instr, sb[0][63:32], sb[0][31:0]);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    void'(sb.pop_front());
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL pushpop_count: instr_valid=%b required 0", instr_valid); end
  endtask

  task automatic test_reset_mid();
    logic        r;
    logic [31:0] a;
    instr_ready = 1'b0;
    do_fetch(32'h300, 32'hBEEF_0000, 1'b1, 1'b0, r, a);
    do_fetch(32'h304, 32'hBEEF_0001, 1'b1, 1'b0, r, a);
    pc_valid = 1'b1;
    pc_in    = 32'h308;
    tick();
    pc_valid = 1'b0;
    mem_gnt  = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h300) begin errors++; $display("FAIL rstmid_pre: v=%b pc=%h required 1 00000300", instr_valid, instr_pc); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_async: v=%b req=%b required 0 0", instr_valid, mem_req); end
    checks++; if (pc_ready !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rstmid_ctl: pc_ready=%b addr=%h required 0 0", pc_ready, mem_addr); end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BAD_0BAD;
    tick();
    mem_rvalid = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stray: instr_valid=%b required 0", instr_valid); end
    checks++; if (pc_ready !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_idle: pc_ready=%b req=%b required 1 0", pc_ready, mem_req); end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    pc_in       = '0;
    pc_valid    = 1'b0;
    flush       = 1'b0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    instr_ready = 1'b0;
    test_reset();
    test_basic();
    test_full_wrap();
    test_flush_wait();
    test_flush_req();
    test_align_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
